// File: rtl/mdu_pkg.sv
// Shared constants and types for the iterative multiply/divide unit.
// Op encodings follow the operation-select field of the integer execute stage.
package mdu_pkg;

  localparam int MDU_WIDTH = 32;

  // Step counter only has to reach WIDTH-1; keep at least one bit for tiny widths.
  function automatic int mdu_cnt_width(input int width);
    return (width > 1) ? $clog2(width) : 1;
  endfunction

  localparam int MDU_CNT_W = mdu_cnt_width(MDU_WIDTH);

  localparam logic [1:0] OP_MULTU = 2'b00;
  localparam logic [1:0] OP_MULT  = 2'b01;
  localparam logic [1:0] OP_DIVU  = 2'b10;
  localparam logic [1:0] OP_DIV   = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_FIX  = 2'd2
  } state_t;

endpackage

// File: rtl/mult_div_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit: one shift-add or restoring-subtract step per
// clock on unsigned magnitudes, with signs applied once in FIX before HI/LO are written.
module mult_div_unit
  import mdu_pkg::*;
#(
  parameter int WIDTH = MDU_WIDTH
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] operand_a,
  input  logic [WIDTH-1:0] operand_b,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CNT_W = mdu_cnt_width(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  logic [WIDTH-1:0]     mcand_q, mcand_d;
  logic                 is_div_q, is_div_d;
  logic                 a_neg_q, a_neg_d;
  logic                 b_neg_q, b_neg_d;
  logic                 dbz_flag_q, dbz_flag_d;
  logic                 done_q, done_d;
  logic                 dbz_q, dbz_d;
  logic [WIDTH-1:0]     hi_q, hi_d;
  logic [WIDTH-1:0]     lo_q, lo_d;

  // Magnitudes are formed in WIDTH+1 bits so the most negative value survives negation.
  logic                 in_signed, in_div;
  logic                 in_a_neg, in_b_neg;
  logic [WIDTH:0]       in_a_sext, in_b_sext;
  logic [WIDTH:0]       in_a_mag, in_b_mag;

  assign in_signed = op[0];
  assign in_div    = op[1];
  assign in_a_neg  = in_signed & operand_a[WIDTH-1];
  assign in_b_neg  = in_signed & operand_b[WIDTH-1];
  assign in_a_sext = {in_a_neg, operand_a};
  assign in_b_sext = {in_b_neg, operand_b};
  assign in_a_mag  = in_a_neg ? -in_a_sext : in_a_sext;
  assign in_b_mag  = in_b_neg ? -in_b_sext : in_b_sext;

  // Multiply step: conditional add into the upper half, then shift the pair right.
  logic [WIDTH:0]       mul_sum;
  logic [2*WIDTH-1:0]   acc_mul;

  assign mul_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, mcand_q};
  assign acc_mul = acc_q[0] ? {mul_sum, acc_q[WIDTH-1:1]}
                            : {1'b0, acc_q[2*WIDTH-1:1]};

  // Divide step: upper half is the partial remainder, lower half the quotient.
  logic [WIDTH:0]       rem_sh, rem_sub;
  logic                 rem_ge;
  logic [2*WIDTH-1:0]   acc_div;

  assign rem_sh  = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
  assign rem_ge  = rem_sh >= {1'b0, mcand_q};
  assign rem_sub = rem_sh - {1'b0, mcand_q};
  assign acc_div = rem_ge ? {rem_sub[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1}
                          : {rem_sh[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};

  // Sign fix. With a zero divisor the remainder already equals the dividend magnitude,
  // so only the quotient needs forcing.
  logic                 res_neg;
  logic [2*WIDTH-1:0]   prod_fix;
  logic [WIDTH-1:0]     quo_fix, rem_fix;

  assign res_neg  = a_neg_q ^ b_neg_q;
  assign prod_fix = res_neg ? -acc_q : acc_q;
  assign quo_fix  = dbz_flag_q ? '1
                  : (res_neg ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0]);
  assign rem_fix  = a_neg_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    acc_d      = acc_q;
    mcand_d    = mcand_q;
    is_div_d   = is_div_q;
    a_neg_d    = a_neg_q;
    b_neg_d    = b_neg_q;
    dbz_flag_d = dbz_flag_q;
    done_d     = 1'b0;
    dbz_d      = 1'b0;
    hi_d       = hi_q;
    lo_d       = lo_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          is_div_d   = in_div;
          a_neg_d    = in_a_neg;
          b_neg_d    = in_b_neg;
          dbz_flag_d = in_div && (operand_b == '0);
          cnt_d      = '0;
          if (in_div) begin
            mcand_d = in_b_mag[WIDTH-1:0];
            acc_d   = {{WIDTH{1'b0}}, in_a_mag[WIDTH-1:0]};
          end else begin
            mcand_d = in_a_mag[WIDTH-1:0];
            acc_d   = {{WIDTH{1'b0}}, in_b_mag[WIDTH-1:0]};
          end
          state_d = ST_CALC;
        end
      end

      ST_CALC: begin
        acc_d = is_div_q ? acc_div : acc_mul;
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          state_d = ST_FIX;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      ST_FIX: begin
        if (is_div_q) begin
          hi_d = rem_fix;
          lo_d = quo_fix;
        end else begin
          hi_d = prod_fix[2*WIDTH-1:WIDTH];
          lo_d = prod_fix[WIDTH-1:0];
        end
        done_d  = 1'b1;
        dbz_d   = dbz_flag_q;
        state_d = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      acc_q      <= '0;
      mcand_q    <= '0;
      is_div_q   <= 1'b0;
      a_neg_q    <= 1'b0;
      b_neg_q    <= 1'b0;
      dbz_flag_q <= 1'b0;
      done_q     <= 1'b0;
      dbz_q      <= 1'b0;
      hi_q       <= '0;
      lo_q       <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      acc_q      <= acc_d;
      mcand_q    <= mcand_d;
      is_div_q   <= is_div_d;
      a_neg_q    <= a_neg_d;
      b_neg_q    <= b_neg_d;
      dbz_flag_q <= dbz_flag_d;
      done_q     <= done_d;
      dbz_q      <= dbz_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
    end
  end

  assign busy        = (state_q != ST_IDLE);
  assign done        = done_q;
  assign div_by_zero = dbz_q;
  assign hi          = hi_q;
  assign lo          = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Randomized and directed bench for mult_div_unit: expected results are queued at issue
// time from plain integer arithmetic and checked by a monitor on every done pulse.
module tb_mult_div_unit;
  import mdu_pkg::*;

  localparam int W = 32;

  logic         clock = 1'b0;
  logic         reset_n = 1'b0;
  logic         start = 1'b0;
  logic [1:0]   op = 2'b00;
  logic [W-1:0] operand_a = '0;
  logic [W-1:0] operand_b = '0;
  logic         busy, done, div_by_zero;
  logic [W-1:0] hi, lo;

  mult_div_unit #(.WIDTH(W)) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .start       (start),
    .op          (op),
    .operand_a   (operand_a),
    .operand_b   (operand_b),
    .busy        (busy),
    .done        (done),
    .div_by_zero (div_by_zero),
    .hi          (hi),
    .lo          (lo)
  );

  // ---------------- clock / reset / cycle count ----------------
  always #5 clock = ~clock;

  longint cyc = 0;
  always @(posedge clock) cyc++;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

  // ---------------- scoreboard state ----------------
  int total = 0;
  int bad = 0;
  logic [2*W:0] exp_q[$];     // {div_by_zero, hi, lo}
  longint       start_q[$];   // cycle count just after the accepting edge
  longint       last_done_cyc = -100;

  task automatic chk(input string name, input logic [71:0] act, input logic [71:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Reference model: the architectural result from plain 64-bit integer arithmetic.
  function automatic logic [2*W:0] model(input logic [1:0] mop, input logic [W-1:0] a,
                                          input logic [W-1:0] b);
    logic [W-1:0]   rh, rl;
    logic           dz;
    longint         sa, sb, sq, sr;
    logic [63:0]    up;
    dz = 1'b0;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    rh = '0;
    rl = '0;
    case (mop)
      OP_MULTU: begin
        up = {32'b0, a} * {32'b0, b};
        rh = up[63:32];
        rl = up[31:0];
      end
      OP_MULT: begin
        up = 64'(sa * sb);
        rh = up[63:32];
        rl = up[31:0];
      end
      default: begin
        if (b == '0) begin
          dz = 1'b1;
          rl = '1;
          rh = a;
        end else if (mop == OP_DIVU) begin
          rl = a / b;
          rh = a % b;
        end else begin
          sq = sa / sb;
          sr = sa % sb;
          up = 64'(sq);
          rl = up[31:0];
          up = 64'(sr);
          rh = up[31:0];
        end
      end
    endcase
    return {dz, rh, rl};
  endfunction

  // ---------------- driver ----------------
  task automatic wait_idle();
    int n = 0;
    @(negedge clock);
    while (busy && n < 200) begin
      @(negedge clock);
      n++;
    end
    if (busy) begin
      total++;
      bad++;
      $display("FAIL idle_wait: got busy=1 want busy=0 within 200 cycles");
    end
  endtask

  task automatic issue(input logic [1:0] mop, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [2*W:0] exp, input bit push, input bit check_b2b);
    wait_idle();
    op        = mop;
    operand_a = a;
    operand_b = b;
    start     = 1'b1;
    @(posedge clock);
    #1;
    start = 1'b0;
    // Operands may wander once captured.
    operand_a = $urandom;
    operand_b = $urandom;
    op        = 2'($urandom_range(0, 3));
    chk("busy_after_start", 72'(busy), 72'(1));
    if (check_b2b) chk("b2b_accept_cycle", 72'(cyc), 72'(last_done_cyc + 1));
    if (push) begin
      exp_q.push_back(exp);
      start_q.push_back(cyc);
    end
  endtask

  function automatic logic [W-1:0] pick_operand();
    case ($urandom_range(0, 7))
      0:       return 32'h0000_0000;
      1:       return 32'h0000_0001;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'h8000_0000;
      4:       return 32'($urandom_range(0, 20));
      default: return 32'($urandom);
    endcase
  endfunction

  // ---------------- monitor ----------------
  always @(negedge clock) begin
    if (reset_n && done) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_done: got done=1 want no pending op (hi=%h lo=%h)", hi, lo);
      end else begin
        logic [2*W:0] e;
        longint       s;
        e = exp_q.pop_front();
        s = start_q.pop_front();
        chk("result_dz_hi_lo", 72'({div_by_zero, hi, lo}), 72'(e));
        chk("latency", 72'(cyc - s), 72'(W + 1));
        chk("busy_at_done", 72'(busy), 72'(0));
      end
      last_done_cyc = cyc;
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [1:0]   rop;
    logic [W-1:0] ra, rb;
    int           n;

    reset_n = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    chk("reset_outputs", 72'({busy, done, div_by_zero, hi, lo}), 72'(0));
    @(negedge clock);
    reset_n = 1'b1;

    // Directed cases with hand-derived results.
    issue(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, {1'b0, 32'hFFFF_FFFE, 32'h0000_0001}, 1, 0);
    issue(OP_MULT,  32'hFFFF_FFFD, 32'd7,         {1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFEB}, 1, 1);
    issue(OP_DIV,   32'hFFFF_FFF9, 32'd2,         {1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFD}, 1, 1);
    issue(OP_DIVU,  32'd100,       32'd7,         {1'b0, 32'd2,         32'd14},        1, 1);
    issue(OP_DIVU,  32'd100,       32'd0,         {1'b1, 32'h0000_0064, 32'hFFFF_FFFF}, 1, 1);
    issue(OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, {1'b0, 32'h0000_0000, 32'h8000_0000}, 1, 1);
    issue(OP_DIV,   32'hFFFF_FFF9, 32'd0,         {1'b1, 32'hFFFF_FFF9, 32'hFFFF_FFFF}, 1, 1);

    // A start mid-operation with different operands must be ignored.
    issue(OP_MULTU, 32'd6, 32'd7, {1'b0, 32'd0, 32'd42}, 1, 1);
    repeat (4) @(negedge clock);
    op        = OP_DIVU;
    operand_a = 32'd99;
    operand_b = 32'd3;
    start     = 1'b1;
    @(posedge clock);
    #1;
    start = 1'b0;
    issue(OP_MULTU, 32'd5, 32'd5, {1'b0, 32'd0, 32'd25}, 1, 1);

    // Reset in the middle of a divide aborts it without a result.
    issue(OP_DIV, 32'hFFFF_FFF9, 32'd2, '0, 0, 1);
    repeat (9) @(negedge clock);
    reset_n = 1'b0;
    #1;
    chk("reset_abort_outputs", 72'({busy, done, div_by_zero, hi, lo}), 72'(0));
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    repeat (40) @(negedge clock);
    chk("no_done_after_abort", 72'({busy, done, hi, lo}), 72'(0));
    issue(OP_MULT, 32'd2, 32'd3, {1'b0, 32'd0, 32'd6}, 1, 0);

    // Randomized operations against the reference model.
    for (int i = 0; i < 40; i++) begin
      rop = 2'($urandom_range(0, 3));
      ra  = pick_operand();
      rb  = pick_operand();
      issue(rop, ra, rb, model(rop, ra, rb), 1, 1);
    end

    n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(negedge clock);
      n++;
    end
    if (exp_q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain: got %0d pending want 0", exp_q.size());
    end
    repeat (2) @(negedge clock);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
